// File: rtl/bridge_pkg.sv
// Shared types for the bridge scheduler: arbiter FSM states and default data width.
`ifndef WIDTH
`define WIDTH 32
`endif

package bridge_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RTZ
  } arb_state_t;

  localparam int DW_DEFAULT = `WIDTH;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator. Scans upward from the source after last_grant
// and remembers the winner only when the caller reports the grant was taken.
module rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int IW      = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] reqs,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_SRC-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] last_grant_q;

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = IW'((int'(last_grant_q) + off) % NUM_SRC);
      if (!found && reqs[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
        grant[idx] = en;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IW'(NUM_SRC - 1);
    end else if (advance) begin
      last_grant_q <= grant_idx;
    end
  end

endmodule

// File: rtl/bridge_rr_arbiter.sv
// Schedules NUM_SRC valid/ready producers onto one 4-phase req/ack channel.
// A word is held from accept until the req/ack return-to-zero cycle finishes.
module bridge_rr_arbiter
  import bridge_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int DW      = DW_DEFAULT,
  parameter  int CNT_W   = 16,
  localparam int IW      = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_SRC-1:0]    valid,
  output logic [NUM_SRC-1:0]    ready,
  input  logic [NUM_SRC*DW-1:0] data_in,
  output logic                  req,
  input  logic                  ack,
  output logic [DW-1:0]         data_out,
  output logic [IW-1:0]         src_id,
  output logic                  busy,
  output logic                  proto_err,
  output logic [CNT_W-1:0]      xfer_cnt
);

  arb_state_t         state_q, state_d;
  logic [DW-1:0]      data_q, data_d;
  logic [IW-1:0]      src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               perr_q, perr_d;

  logic [NUM_SRC-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_en;
  logic               accept;

  // A stray ack in IDLE blocks new grants until the consumer releases it.
  assign grant_en = en & (state_q == ARB_IDLE) & ~ack & ~rst;
  assign ready    = grant;
  assign accept   = |(valid & grant);

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .reqs      (valid),
    .en        (grant_en),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      ARB_IDLE: begin
        if (ack) perr_d = 1'b1;
        if (accept) begin
          state_d = ARB_REQ;
          data_d  = data_in[grant_idx*DW +: DW];
          src_d   = grant_idx;
        end
      end
      ARB_REQ: begin
        if (ack) state_d = ARB_RTZ;
      end
      ARB_RTZ: begin
        if (!ack) begin
          state_d = ARB_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: the holding register is plain flops, so it is cleared on reset along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      data_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  assign req       = (state_q == ARB_REQ);
  assign busy      = (state_q != ARB_IDLE);
  assign data_out  = req ? data_q : '0;
  assign src_id    = src_q;
  assign proto_err = perr_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_bridge_rr_arbiter.sv
// Directed plus randomized bench for bridge_rr_arbiter against a transfer-phase
// reference model; the consumer raises ack one cycle after it sees req and drops it likewise.
module tb_bridge_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  valid;
  logic [N-1:0]  ready;
  logic [N*DW-1:0] data_in;
  logic          req;
  logic          ack;
  logic [DW-1:0] data_out;
  logic [1:0]    src_id;
  logic          busy;
  logic          proto_err;
  logic [CW-1:0] xfer_cnt;

  bridge_rr_arbiter #(.NUM_SRC(N), .DW(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid     (valid),
    .ready     (ready),
    .data_in   (data_in),
    .req       (req),
    .ack       (ack),
    .data_out  (data_out),
    .src_id    (src_id),
    .busy      (busy),
    .proto_err (proto_err),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 = idle, 1 = word offered (waiting for ack), 2 = waiting for ack to fall.
  int            m_phase = 0;
  int            m_last  = N - 1;
  int            m_src   = 0;
  logic [DW-1:0] m_word  = '0;
  int            m_cnt   = 0;
  bit            m_perr  = 1'b0;

  bit auto_ack  = 1'b0;
  bit req_prev  = 1'b0;
  bit req_rose  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    if (rst || m_phase != 0 || ack || !en) return '0;
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (m_last + off) % N;
      if (valid[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = $urandom;
  endtask

  task automatic step();
    logic [N-1:0] r;
    bit           was_rst;
    #1;
    r = model_ready();
    check("ready", ready, r);
    was_rst = rst;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_src = 0; m_word = '0; m_cnt = 0; m_perr = 1'b0;
    end else if (m_phase == 0) begin
      if (ack) m_perr = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          m_src   = i;
          m_word  = data_in[i*DW +: DW];
          m_last  = i;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) m_phase = 2;
    end else begin
      if (!ack) begin
        m_phase = 0;
        m_cnt   = (m_cnt + 1) % (1 << CW);
      end
    end
    @(posedge clk);
    #1;
    req_rose = req && !req_prev;
    check("req", req, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("data_out", data_out, (m_phase == 1) ? m_word : '0);
    check("src_id", src_id, m_src);
    check("proto_err", proto_err, m_perr);
    check("xfer_cnt", xfer_cnt, m_cnt);
    if (auto_ack) ack = was_rst ? 1'b0 : req_prev;
    req_prev = req;
  endtask

  task automatic wait_rise(input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!req_rose && k < 60);
    check({tag, "_req_rise"}, req_rose, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int            order[$];
    int            k;
    int            nb;
    logic [DW-1:0] hold;
    logic [DW-1:0] word0;

    // Reset with every source requesting and ack low.
    rst = 1'b1; en = 1'b1; ack = 1'b0; valid = 4'b1111;
    randomize_data();
    step();
    check("rst_req", req, 1'b0);
    check("rst_cnt", xfer_cnt, 0);
    step();
    check("rst_ready", ready, 4'b0000);
    rst = 1'b0;
    auto_ack = 1'b1;
    #1;
    check("post_rst_ready", ready, 4'b0001);

    // Round robin across all four sources.
    k = 0;
    while (order.size() < 8 && k < 200) begin
      randomize_data();
      step();
      k++;
      if (req_rose) begin
        order.push_back(int'(src_id));
        if (order.size() == 8) valid = '0;
      end
    end
    check("rr_count", order.size(), 8);
    foreach (order[i]) check("rr_order", order[i], i % N);
    wait_idle("rr");
    check("rr_xfer_cnt", xfer_cnt, 8);

    // Single source 2, known word, four busy cycles per transfer.
    valid = 4'b0100;
    data_in[2*DW +: DW] = 32'hA5A5_0002;
    wait_rise("single");
    valid = '0;
    check("single_data", data_out, 32'hA5A5_0002);
    check("single_src", src_id, 2);
    nb = 1;
    k = 0;
    while (busy && k < 60) begin
      step();
      if (busy) nb++;
      k++;
    end
    check("single_busy_cycles", nb, 4);
    check("single_xfer_cnt", xfer_cnt, 9);

    // Stalled ack: REQ holds for 20 cycles while every source keeps requesting.
    auto_ack = 1'b0;
    ack = 1'b0;
    randomize_data();
    valid = 4'b0001;
    wait_rise("stall");
    hold = data_out;
    valid = 4'b1111;
    repeat (20) begin
      step();
      check("stall_req", req, 1'b1);
      check("stall_data", data_out, hold);
      check("stall_ready", ready, 4'b0000);
      check("stall_cnt", xfer_cnt, 9);
    end
    ack = 1'b1;
    step();
    valid = '0;
    ack = 1'b0;
    step();
    check("stall_done_cnt", xfer_cnt, 10);
    auto_ack = 1'b1;

    // en dropped mid-transfer: transfer completes, then no grants until en returns.
    valid = 4'b1000;
    wait_rise("en");
    en = 1'b0;
    wait_idle("en");
    repeat (5) begin
      step();
      check("en_low_ready", ready, 4'b0000);
      check("en_low_busy", busy, 1'b0);
    end
    en = 1'b1;
    #1;
    check("en_high_ready", ready, 4'b1000);
    wait_rise("en_resume");
    valid = '0;
    wait_idle("en_resume");

    // Ack pulse in IDLE: flags a protocol error that sticks.
    auto_ack = 1'b0;
    valid = 4'b0010;
    ack = 1'b1;
    #1;
    check("perr_block_ready", ready, 4'b0000);
    step();
    check("perr_set", proto_err, 1'b1);
    ack = 1'b0;
    valid = '0;
    repeat (3) step();
    check("perr_sticky", proto_err, 1'b1);
    auto_ack = 1'b1;

    // Randomized traffic against the model.
    repeat (400) begin
      valid = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
      randomize_data();
      step();
    end
    en = 1'b1;
    valid = '0;
    wait_idle("random");

    // Reset while a word is offered: word is dropped, source 0 wins next.
    valid = 4'b0100;
    randomize_data();
    wait_rise("rst_req_phase");
    hold = data_out;
    rst = 1'b1;
    valid = 4'b1111;
    randomize_data();
    word0 = hold ^ 32'h1;
    data_in[0 +: DW] = word0;
    step();
    check("rst_mid_req", req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_perr", proto_err, 1'b0);
    rst = 1'b0;
    wait_rise("after_rst");
    check("after_rst_src", src_id, 0);
    check("after_rst_data", data_out, word0);
    check("no_replay", data_out !== hold, 1'b1);
    valid = '0;
    wait_idle("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
